booth_radix4_seq_mult: RTL and testbench
========================================

// Module: booth_radix4_seq_mult
// PURPOSE
//  Parametrised sequential radix-4 (modified) Booth multiplier, successor to the fixed 32-bit radix-2 unit.
//  Retires 2 multiplier bits per cycle, selects signed/unsigned mode per operation and uses
//  valid/ready handshakes on input and output. Sits in the datapath as a shared multi-cycle multiply resource.
// PARAMETERS
//  WIDTH   32  operand width in bits; even, >= 4. Product is 2*WIDTH bits.
//  N       (local) WIDTH/2+1, radix-4 iterations per operation (17 at WIDTH=32).
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          asynchronous, active-low reset (rst=0 clears all state immediately)
//  in_valid     in   1          operand pair valid
//  in_ready     out  1          unit can accept operands (high only in IDLE)
//  in_a         in   WIDTH      multiplicand
//  in_b         in   WIDTH      multiplier
//  in_signed    in   1          1: two's-complement operands; 0: unsigned operands
//  out_valid    out  1          out_product holds a finished result
//  out_ready    in   1          consumer takes result
//  out_product  out  2*WIDTH    product
//  busy         out  1          high in RUN and DONE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_product=0, internal regs=0.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. Accept on in_valid&in_ready at edge k: latch in_a/in_b/in_signed, load
//         count=N, go RUN. in_valid ignored in all other states; inputs may change freely after accept.
//   RUN:  one radix-4 step per edge on bit triple {b[2i+1],b[2i],b[2i-1]} (b[-1]=0):
//         000/111:+0, 001/010:+A, 011:+2A, 100:-2A, 101/110:-A; partial product then arithmetic shift right by 2.
//         Internal operands are WIDTH+2 bits: sign-extended if in_signed=1, zero-extended if 0,
//         so unsigned full-range values multiply exactly. Accumulator WIDTH+4 bits wide, no overflow.
//         count decrements each edge; on the edge where count==1, write out_product and go DONE.
//   DONE: out_valid=1, out_product stable. On out_ready=1 at an edge: out_valid=0, go IDLE.
//         out_product keeps last value after handshake (cleared only by reset).
//  Latency: out_valid high after edge k+N (N cycles after accept); exactly N regardless of operands.
//  Throughput: one op per N+2 cycles with out_ready held high; no accept in the DONE cycle.
//  Backpressure: out_ready=0 holds DONE indefinitely; product and out_valid unchanged.
//  Result = low 2*WIDTH bits of the exact product; exact for all signed and unsigned inputs.
//  Boundaries: most-negative x most-negative (signed) = 2^(2*WIDTH-2), no wrap;
//   all-ones x all-ones unsigned = 2^(2*WIDTH) - 2^(WIDTH+1) + 1.
//  Reset mid-operation (RUN or DONE): operation discarded, outputs at reset values immediately (async);
//   first accept possible at first clk edge with rst=1.
// CONFIGURATION
//  MULT_ZERO_SKIP_EN defined: in IDLE, if accepted in_a==0 or in_b==0, skip RUN and go DONE at edge k+1
//   with out_product=0 (latency 1). All other operands behave as without the macro.
//  MULT_ZERO_SKIP_EN undefined: every operation takes exactly N cycles; no zero detect logic.
// TESTING (WIDTH=32, N=17, out_ready=1 unless stated)
//  1. signed 2 x 5 -> out_valid 17 cycles after accept, out_product=64'd10; in_ready low during RUN/DONE.
//  2. signed 2 x -5 -> 64'hFFFF_FFFF_FFFF_FFF6; signed -132 x -5 -> 64'd660; -132 x 5 -> -660.
//  3. signed 32'h7FFF_FFFF squared -> 64'h3FFF_FFFF_0000_0001; 32'h8000_0000 squared -> 64'h4000_0000_0000_0000;
//     -1 x -1 -> 64'd1.
//  4. unsigned 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001; same operands signed -> 64'd1.
//  5. out_ready=0 for 10 cycles after out_valid -> out_valid and product held, in_valid ignored;
//     then out_ready=1 -> IDLE next edge, next op accepted.
//  6. rst=0 at cycle 8 of RUN -> all outputs reset immediately; next 3 x 7 -> 64'd21 after 17 cycles.
//     With MULT_ZERO_SKIP_EN: 5 x 0 -> out_valid 1 cycle after accept, product 0; without it -> 17 cycles, 0.

Source files
------------

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Define MULT_ZERO_SKIP_EN to finish zero-operand multiplies in one cycle instead of N.
module booth_radix4_seq_mult #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 busy
);

   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);
   localparam int OW = WIDTH + 2;
   localparam int AW = WIDTH + 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] CNT_N   = CW'(N);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [OW-1:0]      mul_q, mul_d;
   logic               bm1_q, bm1_d;
   logic [OW-1:0]      mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [OW-1:0]      a_in_ext, b_in_ext;
   logic [AW-1:0]      a_ext, pp, sum, acc_sh;
   logic [OW-1:0]      mul_sh;

   // Zero- or sign-extension by two bits lets unsigned full-range operands use the signed recoding.
   assign a_in_ext = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
   assign b_in_ext = {{2{in_signed & in_b[WIDTH-1]}}, in_b};

   always_comb begin
      a_ext = {{2{mcand_q[OW-1]}}, mcand_q};
      case ({mul_q[1:0], bm1_q})
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = -(a_ext << 1);
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
      sum    = acc_q + pp;
      // {acc, mul} shifts right arithmetically as one register; mul fills with product low bits.
      acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
      mul_sh = {sum[1:0], mul_q[OW-1:2]};
   end

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path leaves a variable unassigned (no latch).
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      mul_d   = mul_q;
      bm1_d   = bm1_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_RUN;
               count_d = CNT_N;
               acc_d   = '0;
               mul_d   = b_in_ext;
               bm1_d   = 1'b0;
               mcand_d = a_in_ext;
`ifdef MULT_ZERO_SKIP_EN
               // A single step on zeroed operands yields a zero product after one cycle.
               if (in_a == '0 || in_b == '0) begin
                  count_d = CNT_ONE;
                  mul_d   = '0;
                  mcand_d = '0;
               end
`else
`endif
            end
         end
         S_RUN: begin
            acc_d   = acc_sh;
            mul_d   = mul_sh;
            bm1_d   = mul_q[1];
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
               state_d = S_DONE;
               prod_d  = {acc_sh[WIDTH-3:0], mul_sh};
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         acc_q   <= '0;
         mul_q   <= '0;
         bm1_q   <= 1'b0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         mul_q   <= mul_d;
         bm1_q   <= bm1_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign out_product = prod_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed bench for booth_radix4_seq_mult at WIDTH=32: hand-computed products, latency, handshakes, reset.
module tb_booth_radix4_seq_mult;

   localparam int LAT = 17;
`ifdef MULT_ZERO_SKIP_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 17;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_signed = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_product;
   logic        busy;

   int checks = 0;
   int passed = 0;

   booth_radix4_seq_mult #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Present one operand pair, accept it, then wait (bounded) for out_valid.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int exp_lat);
      int lat;
      in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_signed = ~sgn;
      check({tag, "_busy_after_accept"}, {62'd0, in_ready, busy}, 64'd1);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_product"}, out_product, exp);
      if (out_ready) begin
         tick();
         check({tag, "_back_idle"}, {61'd0, in_ready, out_valid, busy}, 64'd4);
         check({tag, "_product_kept"}, out_product, exp);
      end
   endtask

   initial begin
      // Reset state
      #2;
      check("reset_outputs", {61'd0, in_ready, out_valid, busy}, 64'd4);
      check("reset_product", out_product, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;

      run_op("s_2x5",       32'd2,          32'd5,          1'b1, 64'd10, LAT);
      run_op("s_2xm5",      32'd2,          32'hFFFF_FFFB,  1'b1, 64'hFFFF_FFFF_FFFF_FFF6, LAT);
      run_op("s_m132xm5",   32'hFFFF_FF7C,  32'hFFFF_FFFB,  1'b1, 64'd660, LAT);
      run_op("s_m132x5",    32'hFFFF_FF7C,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FD6C, LAT);
      run_op("s_maxpos_sq", 32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1, 64'h3FFF_FFFF_0000_0001, LAT);
      run_op("s_maxneg_sq", 32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, LAT);
      run_op("s_m1xm1",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'd1, LAT);
      run_op("u_ones_sq",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, LAT);
      run_op("u_msb_x2",    32'h8000_0000,  32'd2,          1'b0, 64'h0000_0001_0000_0000, LAT);
      run_op("u_mixed",     32'h1234_5678,  32'h0000_1000,  1'b0, 64'h0000_0123_4567_8000, LAT);

      // Backpressure: DONE held while out_ready is low; new operands ignored.
      out_ready = 1'b0;
      run_op("bp_op", 32'd6, 32'd7, 1'b0, 64'd42, LAT);
      in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
      for (int i = 0; i < 10; i++) tick();
      check("bp_held_valid", {62'd0, out_valid, in_ready}, 64'd2);
      check("bp_held_product", out_product, 64'd42);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_idle", {62'd0, in_ready, out_valid}, 64'd2);
      run_op("bp_next", 32'd11, 32'd13, 1'b0, 64'd143, LAT);

      // Asynchronous reset in the middle of RUN.
      in_a = 32'd100; in_b = 32'd100; in_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("mid_run_busy", 64'(busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_outputs", {61'd0, in_ready, out_valid, busy}, 64'd4);
      check("async_rst_product", out_product, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      run_op("after_rst_3x7", 32'd3, 32'd7, 1'b0, 64'd21, LAT);

      // Zero operand: one cycle with the skip option, full latency without it.
      run_op("zero_5x0", 32'd5, 32'd0, 1'b1, 64'd0, ZLAT);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
